// File: rtl/decode_stage.sv
// Instruction-decode stage: splits a MIPS-32 word, reads rs/rt from a 32x32
// register file with write-back bypass, and holds decoded operands for the ALU.
module decode_stage (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        IN_READY,
    input  logic        WB_EN,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [5:0]  OPCODE,
    output logic [31:0] RS_VAL,
    output logic [31:0] RT_VAL,
    output logic [4:0]  SHAMT,
    output logic [5:0]  FUNC,
    output logic [15:0] RAW_VAL,
    output logic [4:0]  RD_ADDR
);

    // Handshake: a transfer happens on an edge where INSTR_VALID && IN_READY.
    // IN_READY = !OUT_VALID || OUT_READY, so a consumed slot refills without a bubble.

    logic [31:0] rf [32];
    logic [4:0]  held_rs;
    logic [4:0]  held_rt;

    logic [5:0]  f_opcode;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_shamt;
    logic [5:0]  f_func;
    logic [15:0] f_imm;
    logic [31:0] rs_rd;
    logic [31:0] rt_rd;
    logic        wb_live;
    logic        accept;

    assign f_opcode = INSTR[31:26];
    assign f_rs     = INSTR[25:21];
    assign f_rt     = INSTR[20:16];
    assign f_rd     = INSTR[15:11];
    assign f_shamt  = INSTR[10:6];
    assign f_func   = INSTR[5:0];
    assign f_imm    = INSTR[15:0];

    assign wb_live  = WB_EN && (WB_ADDR != 5'd0);
    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = INSTR_VALID && IN_READY;

    // R0 reads as zero; a same-edge write-back wins over the stale array entry.
    always_comb begin
        rs_rd = rf[f_rs];
        rt_rd = rf[f_rt];
        if (f_rs == 5'd0)
            rs_rd = '0;
        else if (wb_live && WB_ADDR == f_rs)
            rs_rd = WB_DATA;
        if (f_rt == 5'd0)
            rt_rd = '0;
        else if (wb_live && WB_ADDR == f_rt)
            rt_rd = WB_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (wb_live) begin
            rf[WB_ADDR] <= WB_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OPCODE    <= '0;
            RS_VAL    <= '0;
            RT_VAL    <= '0;
            SHAMT     <= '0;
            FUNC      <= '0;
            RAW_VAL   <= '0;
            RD_ADDR   <= '0;
            held_rs   <= '0;
            held_rt   <= '0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            OPCODE    <= f_opcode;
            RS_VAL    <= rs_rd;
            RT_VAL    <= rt_rd;
            SHAMT     <= f_shamt;
            FUNC      <= f_func;
            RAW_VAL   <= f_imm;
            RD_ADDR   <= (f_opcode == 6'd0) ? f_rd : f_rt;
            held_rs   <= f_rs;
            held_rt   <= f_rt;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end else if (OUT_VALID) begin
            // Stalled: keep held operands coherent with write-backs landing now.
            if (wb_live && WB_ADDR == held_rs)
                RS_VAL <= WB_DATA;
            if (wb_live && WB_ADDR == held_rt)
                RT_VAL <= WB_DATA;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for streaming decode plus
// hand-written stall, flush and async-reset sequences.
module tb_decode_stage;

    logic        CLK;
    logic        RST_N;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        IN_READY;
    logic        WB_EN;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [5:0]  OPCODE;
    logic [31:0] RS_VAL;
    logic [31:0] RT_VAL;
    logic [4:0]  SHAMT;
    logic [5:0]  FUNC;
    logic [15:0] RAW_VAL;
    logic [4:0]  RD_ADDR;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .CLK(CLK), .RST_N(RST_N), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .IN_READY(IN_READY), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OPCODE(OPCODE), .RS_VAL(RS_VAL), .RT_VAL(RT_VAL), .SHAMT(SHAMT),
        .FUNC(FUNC), .RAW_VAL(RAW_VAL), .RD_ADDR(RD_ADDR)
    );

    // Clock/reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [5:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] raw;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [31:0] instr, input logic valid, input logic ord,
                         input logic wb_en, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                         input logic flush);
        INSTR       = instr;
        INSTR_VALID = valid;
        OUT_READY   = ord;
        WB_EN       = wb_en;
        WB_ADDR     = wb_addr;
        WB_DATA     = wb_data;
        FLUSH       = flush;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0022_1825, 1'b0, 5'd0, 32'h0,         6'h00, 32'h5,  32'h2,  5'd0,  6'h25, 16'h1825, 5'd3};
        vecs[1] = '{32'h2024_FFFF, 1'b1, 5'd1, 32'h10,        6'h08, 32'h10, 32'h0,  5'd31, 6'h3F, 16'hFFFF, 5'd4};
        vecs[2] = '{32'h0001_2820, 1'b1, 5'd0, 32'hDEADBEEF,  6'h00, 32'h0,  32'h10, 5'd0,  6'h20, 16'h2820, 5'd5};
        vecs[3] = '{32'h0002_3100, 1'b0, 5'd0, 32'h0,         6'h00, 32'h0,  32'h2,  5'd4,  6'h00, 16'h3100, 5'd6};
        vecs[4] = '{32'h8C47_0008, 1'b0, 5'd0, 32'h0,         6'h23, 32'h2,  32'h0,  5'd0,  6'h08, 16'h0008, 5'd7};
        vecs[5] = '{32'h0022_1825, 1'b1, 5'd2, 32'h77,        6'h00, 32'h10, 32'h77, 5'd0,  6'h25, 16'h1825, 5'd3};

        RST_N = 1'b0;
        drive(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        #12;
        check("reset_out_valid", {31'h0, OUT_VALID}, 32'h0);
        check("reset_in_ready", {31'h0, IN_READY}, 32'h1);
        check("reset_rs_val", RS_VAL, 32'h0);
        check("reset_opcode", {26'h0, OPCODE}, 32'h0);
        RST_N = 1'b1;
        step();

        drive(32'h0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h5, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h2, 1'b0);
        step();

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].instr, 1'b1, 1'b1, vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data, 1'b0);
            step();
            check($sformatf("v%0d_out_valid", i), {31'h0, OUT_VALID}, 32'h1);
            check($sformatf("v%0d_opcode", i), {26'h0, OPCODE}, {26'h0, vecs[i].op});
            check($sformatf("v%0d_rs_val", i), RS_VAL, vecs[i].rs);
            check($sformatf("v%0d_rt_val", i), RT_VAL, vecs[i].rt);
            check($sformatf("v%0d_shamt", i), {27'h0, SHAMT}, {27'h0, vecs[i].sh});
            check($sformatf("v%0d_func", i), {26'h0, FUNC}, {26'h0, vecs[i].fn});
            check($sformatf("v%0d_raw_val", i), {16'h0, RAW_VAL}, {16'h0, vecs[i].raw});
            check($sformatf("v%0d_rd_addr", i), {27'h0, RD_ADDR}, {27'h0, vecs[i].rd});
        end

        // Stall with held-operand refresh, then accept-and-consume on release
        drive(32'h0022_1825, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        check("stall_in_ready", {31'h0, IN_READY}, 32'h0);
        drive(32'h8C47_0008, 1'b1, 1'b0, 1'b1, 5'd2, 32'hAA, 1'b0);
        step();
        check("stall_out_valid", {31'h0, OUT_VALID}, 32'h1);
        check("stall_opcode", {26'h0, OPCODE}, 32'h0);
        check("stall_rt_refresh", RT_VAL, 32'hAA);
        check("stall_rs_held", RS_VAL, 32'h10);
        drive(32'h8C47_0008, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("stall2_rt_held", RT_VAL, 32'hAA);
        check("stall2_func", {26'h0, FUNC}, 32'h25);
        check("stall2_in_ready", {31'h0, IN_READY}, 32'h0);
        drive(32'h8C47_0008, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("release_opcode", {26'h0, OPCODE}, 32'h23);
        check("release_rs_val", RS_VAL, 32'hAA);
        check("release_rd_addr", {27'h0, RD_ADDR}, 32'h7);
        check("release_out_valid", {31'h0, OUT_VALID}, 32'h1);

        // Consume with no new instruction: valid drops, data holds
        drive(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("drain_out_valid", {31'h0, OUT_VALID}, 32'h0);
        check("drain_opcode_hold", {26'h0, OPCODE}, 32'h23);

        // Flush discards a same-cycle accept; write-back still lands
        drive(32'h0022_1825, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("pre_flush_valid", {31'h0, OUT_VALID}, 32'h1);
        drive(32'h8C47_0008, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 1'b1);
        step();
        check("flush_out_valid", {31'h0, OUT_VALID}, 32'h0);
        check("flush_discard_opcode", {26'h0, OPCODE}, 32'h0);
        drive(32'h0120_5020, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("post_flush_valid", {31'h0, OUT_VALID}, 32'h1);
        check("post_flush_rs_val", RS_VAL, 32'h99);
        check("post_flush_rd_addr", {27'h0, RD_ADDR}, 32'hA);
        check("post_flush_func", {26'h0, FUNC}, 32'h20);

        // Asynchronous reset mid-stall
        drive(32'h0022_1825, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("pre_reset_stall_valid", {31'h0, OUT_VALID}, 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_valid", {31'h0, OUT_VALID}, 32'h0);
        check("async_reset_rs_val", RS_VAL, 32'h0);
        check("async_reset_rt_val", RT_VAL, 32'h0);
        check("async_reset_func", {26'h0, FUNC}, 32'h0);
        check("async_reset_raw", {16'h0, RAW_VAL}, 32'h0);
        check("async_reset_rd", {27'h0, RD_ADDR}, 32'h0);
        check("async_reset_in_ready", {31'h0, IN_READY}, 32'h1);
        #2;
        RST_N = 1'b1;
        drive(32'h0022_1825, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("after_reset_valid", {31'h0, OUT_VALID}, 32'h1);
        check("after_reset_r1", RS_VAL, 32'h0);
        check("after_reset_r2", RT_VAL, 32'h0);
        check("after_reset_func", {26'h0, FUNC}, 32'h25);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
